// File: rtl/cooktime_countdown_if.sv
// Cook-time display/control bundle between the oven controller and the countdown block.
// Master drives enable, start button and set digits; slave returns display digits and indicators.
interface cooktime_countdown_if;
    logic       main_enable;
    logic       start_in;
    logic [3:0] set_ones;
    logic [3:0] set_tens;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       alarm;

    modport master (
        output main_enable, start_in, set_ones, set_tens,
        input  ones, tens, running, alarm
    );

    modport slave (
        input  main_enable, start_in, set_ones, set_tens,
        output ones, tens, running, alarm
    );
endinterface

// File: rtl/cooktime_countdown.sv
// Purpose: loads the BCD cook time on a start press, counts it down once per second, then alarms.
// Latency: all outputs registered, updated on the edge after the condition; optional COOKTIME_PAUSE_EN.
// Backpressure: none; main_enable low freezes state, start edges are tracked but suppressed.
module cooktime_countdown #(
    parameter int TICKS_PER_SEC = 10,
    parameter int ALARM_SECS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    cooktime_countdown_if.slave   bus
);

    localparam int PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int ALARM_CYC = ALARM_SECS * TICKS_PER_SEC;
    localparam int TW        = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ALARM_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t        state_q,   state_d;
    logic [3:0]    ones_q,    ones_d;
    logic [3:0]    tens_q,    tens_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          running_q, running_d;
    logic          alarm_q,   alarm_d;
    logic          start_q,   start_d;

    logic       start_evt;
    logic [3:0] set_ones_c;
    logic [3:0] set_tens_c;

    assign start_evt  = bus.start_in & ~start_q & bus.main_enable;
    assign set_ones_c = (bus.set_ones > 4'd9) ? 4'd9 : bus.set_ones;
    assign set_tens_c = (bus.set_tens > 4'd9) ? 4'd9 : bus.set_tens;

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        presc_d   = presc_q;
        timer_d   = timer_q;
        running_d = running_q;
        alarm_d   = alarm_q;
        // Edge detector keeps tracking the button even while disabled.
        start_d   = bus.start_in;

        if (bus.main_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_evt && ({set_tens_c, set_ones_c} != 8'h00)) begin
                        state_d   = ST_RUN;
                        ones_d    = set_ones_c;
                        tens_d    = set_tens_c;
                        presc_d   = '0;
                        running_d = 1'b1;
                    end else begin
                        ones_d = set_ones_c;
                        tens_d = set_tens_c;
                    end
                end

                ST_RUN: begin
`ifdef COOKTIME_PAUSE_EN
                    if (start_evt) begin
                        state_d = ST_PAUSE;
                    end else
`endif
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        // 01 (or a defensive 00) finishes the count; never borrow past zero.
                        if ((tens_q == 4'd0) && (ones_q <= 4'd1)) begin
                            ones_d    = 4'd0;
                            state_d   = ST_ALARM;
                            running_d = 1'b0;
                            alarm_d   = 1'b1;
                            timer_d   = '0;
                        end else if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end

                ST_ALARM: begin
                    if (start_evt || (timer_q == TIMER_LAST)) begin
                        state_d = ST_IDLE;
                        alarm_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                ST_PAUSE: begin
`ifdef COOKTIME_PAUSE_EN
                    if (start_evt) begin
                        state_d = ST_RUN;
                    end
`else
                    state_d   = ST_IDLE;
                    running_d = 1'b0;
`endif
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            presc_q   <= '0;
            timer_q   <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            start_q   <= start_d;
        end
    end

    assign bus.ones    = ones_q;
    assign bus.tens    = tens_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_cooktime_countdown.sv
// Randomised plus directed stimulus for cooktime_countdown against a seconds-remaining reference model.
// Expected outputs are queued per cycle; an independent monitor compares them after each edge.
module tb_cooktime_countdown;

    localparam int TPS = 10;
    localparam int AS  = 3;
`ifdef COOKTIME_PAUSE_EN
    localparam bit PAUSE_BUILT = 1'b1;
`else
    localparam bit PAUSE_BUILT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cooktime_countdown_if bus ();

    cooktime_countdown #(
        .TICKS_PER_SEC (TPS),
        .ALARM_SECS    (AS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       running;
        logic       alarm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: whole seconds left, cycles into the current second,
    // cycles of alarm left, and the last set value shown while idle.
    int secs_left  = 0;
    int sub        = 0;
    int alarm_left = 0;
    int shown      = 0;
    bit counting   = 0;
    bit paused     = 0;
    bit prev_start = 0;

    task automatic model(input bit rst, input bit en, input bit st, input int so, input int tn);
        bit evt;
        int setv;
        if (rst) begin
            secs_left = 0; sub = 0; alarm_left = 0; shown = 0;
            counting = 0; paused = 0; prev_start = 0;
        end else begin
            evt        = st && !prev_start && en;
            prev_start = st;
            if (en) begin
                setv = ((tn > 9) ? 9 : tn) * 10 + ((so > 9) ? 9 : so);
                if (alarm_left > 0) begin
                    if (evt || alarm_left == 1) alarm_left = 0;
                    else alarm_left--;
                end else if (counting) begin
                    if (PAUSE_BUILT && evt) begin
                        paused = !paused;
                    end else if (!paused) begin
                        sub++;
                        if (sub == TPS) begin
                            sub = 0;
                            secs_left--;
                            if (secs_left == 0) begin
                                counting   = 0;
                                alarm_left = AS * TPS;
                                shown      = 0;
                            end
                        end
                    end
                end else begin
                    if (evt && setv != 0) begin
                        counting  = 1;
                        paused    = 0;
                        secs_left = setv;
                        sub       = 0;
                    end else begin
                        shown = setv;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit st, input int so, input int tn);
        exp_t e;
        int   val;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.main_enable = en;
        bus.start_in    = st;
        bus.set_ones    = 4'(so);
        bus.set_tens    = 4'(tn);
        model(rst, en, st, so, tn);
        val       = counting ? secs_left : shown;
        e.tgt     = cyc + 1;
        e.tens    = 4'(val / 10);
        e.ones    = 4'(val % 10);
        e.running = counting;
        e.alarm   = (alarm_left > 0);
        sb.push_back(e);
    endtask

    task automatic run(input int n, input bit en, input bit st, input int so, input int tn);
        for (int i = 0; i < n; i++) step(1'b0, en, st, so, tn);
    endtask

    task automatic press(input int so, input int tn);
        step(1'b0, 1'b1, 1'b1, so, tn);
        step(1'b0, 1'b1, 1'b0, so, tn);
    endtask

    // Monitor: one comparison per clock once the matching expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0 && sb[0].tgt <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.tgt != cyc || bus.tens !== e.tens || bus.ones !== e.ones ||
                    bus.running !== e.running || bus.alarm !== e.alarm) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d (exp for %0d): got tens=%0d ones=%0d running=%b alarm=%b, expected tens=%0d ones=%0d running=%b alarm=%b",
                             cyc, e.tgt, bus.tens, bus.ones, bus.running, bus.alarm,
                             e.tens, e.ones, e.running, e.alarm);
                end
            end
        end
    end

    initial begin
        bit st_r;
        int so_r;
        int tn_r;
        bus.main_enable = 1'b0;
        bus.start_in    = 1'b0;
        bus.set_ones    = 4'd0;
        bus.set_tens    = 4'd0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0);

        // Start with 00: must stay idle.
        run(2, 1, 0, 0, 0);
        press(0, 0);
        run(5, 1, 0, 0, 0);

        // 12 seconds to alarm, then alarm timeout back to idle.
        run(2, 1, 0, 2, 1);
        press(2, 1);
        run(125, 1, 0, 2, 1);
        run(35, 1, 0, 2, 1);

        // 10 -> 09 borrow, alarm, then digits track new set inputs.
        run(2, 1, 0, 0, 1);
        press(0, 1);
        run(140, 1, 0, 0, 1);
        run(5, 1, 0, 3, 4);

        // Freeze at 07 with button edges while disabled, then long press.
        press(8, 0);
        run(11, 1, 0, 8, 0);
        run(10, 0, 0, 8, 0);
        run(15, 0, 1, 8, 0);
        run(40, 1, 1, 8, 0);
        run(20, 1, 0, 8, 0);
        press(8, 0);
        run(120, 1, 0, 8, 0);

        // Reset in the middle of a run.
        press(0, 3);
        run(15, 1, 0, 0, 3);
        step(1'b1, 1'b1, 1'b0, 0, 3);
        run(5, 1, 0, 0, 3);

        // Pause/resume around 03, then finish.
        press(5, 0);
        run(20, 1, 0, 5, 0);
        press(5, 0);
        run(50, 1, 0, 5, 0);
        press(5, 0);
        run(70, 1, 0, 5, 0);

        // Alarm acknowledged by a press.
        press(1, 0);
        run(14, 1, 0, 1, 0);
        press(1, 0);
        run(3, 1, 0, 1, 0);

        // Out-of-range set digits clamp to 99; full-length countdown.
        run(3, 1, 0, 12, 15);
        press(12, 15);
        run(1000, 1, 0, 12, 15);

        // Randomised traffic.
        st_r = 1'b0;
        so_r = 0;
        tn_r = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 14) == 0) st_r = ~st_r;
            if ($urandom_range(0, 39) == 0) begin
                so_r = $urandom_range(0, 15);
                tn_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            end
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0), st_r, so_r, tn_r);
        end
        run(3, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
